io_port_ctrl: RTL and testbench

Memory-mapped I/O controller on the PMIPSL1 data-memory bus, alongside the data RAM in the data-memory device. It decodes a small I/O window at the top of the 16-bit address space and provides a 7-segment display register, synchronised and debounced slide switches (io_sw0, io_sw1) with sticky rising-edge flags, and a free-running 16-bit cycle timer. The data-memory device muxes `rdata` onto the processor read bus whenever `sel` is high.

---
 rtl/io_port_ctrl_pkg.sv | 33 +++
 rtl/sw_debounce.sv | 50 +++++
 rtl/io_port_ctrl.sv | 138 +++++++++++++
 tb/tb_io_port_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_ctrl_pkg.sv
// Shared definitions for the io_port_ctrl memory-mapped I/O block:
// register offsets, TCTL bit positions and the blank display pattern.
package io_port_ctrl_pkg;

   localparam logic [2:0] OFS_DISP = 3'd0;
   localparam logic [2:0] OFS_SW   = 3'd2;
   localparam logic [2:0] OFS_TCNT = 3'd4;
   localparam logic [2:0] OFS_TCTL = 3'd6;

   localparam int TCTL_EN_BIT  = 0;
   localparam int TCTL_CLR_BIT = 1;
   localparam int TCTL_OVF_BIT = 2;

   localparam logic [6:0] DISP_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      REG_DISP,
      REG_SW,
      REG_TCNT,
      REG_TCTL
   } io_reg_e;

   // Byte-offset decode of the word address inside the window (addr[0] ignored).
   function automatic io_reg_e decode_reg(input logic [1:0] word);
      case ({word, 1'b0})
         OFS_SW:   return REG_SW;
         OFS_TCNT: return REG_TCNT;
         OFS_TCTL: return REG_TCTL;
         default:  return REG_DISP;
      endcase
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// One slide switch: 2-flop synchroniser, stability counter and a one-cycle
// pulse on the edge where the debounced value goes 0 -> 1.
module sw_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_i,
   output logic db_o,
   output logic rise_o
);

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic       sync1_q, sync2_q;
   logic       db_q, db_d;
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      db_d   = db_q;
      rise_o = 1'b0;
      if (sync2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         db_d   = sync2_q;
         cnt_d  = '0;
         rise_o = sync2_q;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign db_o = db_q;

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O window: display register, debounced switches with sticky
// rise flags and, when IO_TIMER_EN is defined, a 16-bit cycle timer.
module io_port_ctrl
   import io_port_ctrl_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 4,
   parameter logic [15:0] BASE_ADDR       = 16'hFFF0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   input  logic        memwrite,
   input  logic        memread,
   output logic [15:0] rdata,
   output logic        sel,
   input  logic        io_sw0,
   input  logic        io_sw1,
   output logic [6:0]  io_display
);

   io_reg_e     reg_sel;
   logic        wr_en, rd_en, sw_rd;
   logic [6:0]  disp_q, disp_d;
   logic [1:0]  rise_q, rise_d;
   logic [1:0]  sw_raw, sw_db, sw_rise;
   logic [15:0] tcnt_rd, tctl_rd;
   logic        unused_bits;

   assign sel         = (addr[15:3] == BASE_ADDR[15:3]);
   assign reg_sel     = decode_reg(addr[2:1]);
   assign wr_en       = memwrite && sel;
   assign rd_en       = memread && sel;
   assign sw_rd       = rd_en && (reg_sel == REG_SW);
   assign unused_bits = ^{addr[0], wdata};

   assign sw_raw = {io_sw1, io_sw0};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sw
         sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_sw_debounce (
            .clock (clock),
            .reset (reset),
            .raw_i (sw_raw[gi]),
            .db_o  (sw_db[gi]),
            .rise_o(sw_rise[gi])
         );
      end
   endgenerate

   // A rise landing on the same edge as an SW read survives the clear.
   always_comb begin
      disp_d = disp_q;
      rise_d = sw_rise | (rise_q & ~{2{sw_rd}});
      if (wr_en && (reg_sel == REG_DISP)) begin
         disp_d = wdata[6:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         disp_q <= DISP_BLANK;
         rise_q <= '0;
      end else begin
         disp_q <= disp_d;
         rise_q <= rise_d;
      end
   end

`ifdef IO_TIMER_EN
   logic [15:0] tcnt_q, tcnt_d;
   logic        en_q, en_d, ovf_q, ovf_d;
   logic        tcnt_wr, tctl_wr;

   assign tcnt_wr = wr_en && (reg_sel == REG_TCNT);
   assign tctl_wr = wr_en && (reg_sel == REG_TCTL);

   // Increment uses the enable held before this edge; clear beats load beats count.
   always_comb begin
      tcnt_d = tcnt_q;
      en_d   = en_q;
      ovf_d  = ovf_q;
      if (tctl_wr) begin
         en_d = wdata[TCTL_EN_BIT];
         if (wdata[TCTL_OVF_BIT]) begin
            ovf_d = 1'b0;
         end
      end
      if (tctl_wr && wdata[TCTL_CLR_BIT]) begin
         tcnt_d = '0;
      end else if (tcnt_wr) begin
         tcnt_d = wdata;
      end else if (en_q) begin
         tcnt_d = tcnt_q + 16'd1;
         if (tcnt_q == 16'hFFFF) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tcnt_q <= '0;
         en_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         en_q   <= en_d;
         ovf_q  <= ovf_d;
      end
   end

   assign tcnt_rd = tcnt_q;
   assign tctl_rd = {13'b0, ovf_q, 1'b0, en_q};
`else
   assign tcnt_rd = '0;
   assign tctl_rd = '0;
`endif

   always_comb begin
      rdata = '0;
      if (rd_en) begin
         case (reg_sel)
            REG_DISP: rdata = {9'b0, disp_q};
            REG_SW:   rdata = {12'b0, rise_q, sw_db};
            REG_TCNT: rdata = tcnt_rd;
            REG_TCTL: rdata = tctl_rd;
            default:  rdata = '0;
         endcase
      end
   end

   assign io_display = disp_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Scoreboard bench for io_port_ctrl: reads push expected values from a
// behavioural model; a negedge monitor pops and compares.
module tb_io_port_ctrl;

   localparam int DB = 4;
`ifdef IO_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] addr = '0;
   logic [15:0] wdata = '0;
   logic        memwrite = 1'b0;
   logic        memread = 1'b0;
   logic        io_sw0 = 1'b0;
   logic        io_sw1 = 1'b0;
   logic [15:0] rdata;
   logic        sel;
   logic [6:0]  io_display;

   always #5 clock = ~clock;

   io_port_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .BASE_ADDR(16'hFFF0)
   ) dut (
      .clock(clock),
      .reset(reset),
      .addr(addr),
      .wdata(wdata),
      .memwrite(memwrite),
      .memread(memread),
      .rdata(rdata),
      .sel(sel),
      .io_sw0(io_sw0),
      .io_sw1(io_sw1),
      .io_display(io_display)
   );

   typedef struct {
      logic [15:0] addr;
      logic [15:0] rdata;
      logic        sel;
      logic [6:0]  disp;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   passes = 0;

   // Reference model state
   logic [6:0]  m_disp;
   bit          m_deb [2];
   bit          m_rise[2];
   logic [15:0] m_rawh[2];   // raw switch value seen at each edge, newest in bit 0
   logic [15:0] m_synh[2];   // synchronised sample used at each edge, newest in bit 0
   logic [15:0] m_tcnt;
   bit          m_en, m_ovf;

   function automatic bit in_win(input logic [15:0] a);
      return (a >= 16'hFFF0) && (a <= 16'hFFF7);
   endfunction

   function automatic int reg_index(input logic [15:0] a);
      return int'(a - 16'hFFF0) / 2;
   endfunction

   function automatic logic [15:0] model_read(input logic [15:0] a);
      if (!in_win(a)) return 16'h0000;
      case (reg_index(a))
         0: return {9'b0, m_disp};
         1: return {12'b0, m_rise[1], m_rise[0], m_deb[1], m_deb[0]};
         2: return TIMER ? m_tcnt : 16'h0000;
         default: return TIMER ? {13'b0, m_ovf, 1'b0, m_en} : 16'h0000;
      endcase
   endfunction

   task automatic model_reset();
      m_disp = 7'h7F;
      m_tcnt = '0;
      m_en   = 1'b0;
      m_ovf  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_deb[i]  = 1'b0;
         m_rise[i] = 1'b0;
         m_rawh[i] = '0;
         m_synh[i] = '0;
      end
   endtask

   // Effect of one rising edge with the given bus inputs.
   task automatic model_step(input logic [15:0] a, input logic [15:0] wd, input bit w, input bit r);
      bit          wr, sw_rd, rise_set, ovf_set, old_en;
      int          ri;
      logic [15:0] mask, win;
      wr    = w && in_win(a);
      ri    = reg_index(a);
      sw_rd = r && in_win(a) && (ri == 1);
      mask  = 16'((1 << DB) - 1);
      for (int i = 0; i < 2; i++) begin
         m_rawh[i] = {m_rawh[i][14:0], (i == 0) ? io_sw0 : io_sw1};
         // the synchroniser delivers the value seen two edges earlier
         m_synh[i] = {m_synh[i][14:0], m_rawh[i][2]};
         win       = m_synh[i] & mask;
         rise_set  = 1'b0;
         if (m_deb[i] ? (win == 16'h0000) : (win == mask)) begin
            rise_set = !m_deb[i];
            m_deb[i] = !m_deb[i];
         end
         m_rise[i] = rise_set || (m_rise[i] && !sw_rd);
      end
      if (wr && ri == 0) m_disp = wd[6:0];
      if (TIMER) begin
         old_en  = m_en;
         ovf_set = 1'b0;
         if (wr && ri == 3 && wd[1]) m_tcnt = 16'h0000;
         else if (wr && ri == 2) m_tcnt = wd;
         else if (old_en) begin
            if (m_tcnt == 16'hFFFF) begin
               m_tcnt  = 16'h0000;
               ovf_set = 1'b1;
            end else begin
               m_tcnt = m_tcnt + 16'd1;
            end
         end
         if (wr && ri == 3) m_en = wd[0];
         m_ovf = ovf_set || (m_ovf && !(wr && ri == 3 && wd[2]));
      end
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, expv);
   endtask

   // Called at posedge+1; drives one bus cycle and advances the model across the edge.
   task automatic bus(input logic [15:0] a, input logic [15:0] wd, input bit w, input bit r);
      exp_t e;
      addr     = a;
      wdata    = wd;
      memwrite = w;
      memread  = r;
      if (r) begin
         e.addr  = a;
         e.rdata = model_read(a);
         e.sel   = in_win(a);
         e.disp  = m_disp;
         sb_q.push_back(e);
      end
      if (w) $display("wr addr=%h data=%h", a, wd);
      @(posedge clock);
      if (reset) model_reset();
      else model_step(a, wd, w, r);
      #1;
      memwrite = 1'b0;
      memread  = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a);
      bus(a, 16'h0000, 1'b0, 1'b1);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      bus(a, d, 1'b1, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus(16'h0000, 16'h0000, 1'b0, 1'b0);
   endtask

   // Reset asserted mid-cycle; register reads taken while it is held.
   task automatic async_reset();
      #2;
      reset = 1'b1;
      model_reset();
      @(posedge clock);
      #1;
      rd(16'hFFF0);
      rd(16'hFFF2);
      rd(16'hFFF4);
      rd(16'hFFF6);
      reset = 1'b0;
   endtask

   always @(negedge clock) begin : monitor
      exp_t e;
      if (memread) begin
         if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL sb_underflow: got read at %h expected none", addr);
         end else begin
            e = sb_q.pop_front();
            $display("rd addr=%h rdata=%h exp=%h sel=%b disp=%h", e.addr, rdata, e.rdata, sel, io_display);
            chk("rdata", rdata, e.rdata);
            chk("sel", {15'b0, sel}, {15'b0, e.sel});
            chk("io_display", {9'b0, io_display}, {9'b0, e.disp});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] a, d;
      int          hold, op, k;
      model_reset();
      idle(2);
      rd(16'hFFF0);
      rd(16'hFFF2);
      reset = 1'b0;
      idle(1);

      // dirty state, then asynchronous reset mid-cycle
      wr(16'hFFF0, 16'h0012);
      wr(16'hFFF4, 16'h1234);
      wr(16'hFFF6, 16'h0001);
      idle(2);
      async_reset();

      // display write and out-of-window write
      wr(16'hFFF0, 16'h1240);
      rd(16'hFFF0);
      rd(16'hFFF1);
      wr(16'hFFF8, 16'h0055);
      rd(16'hFFF8);
      rd(16'hFFF0);

      // 3-cycle glitch rejected
      io_sw0 = 1'b1;
      idle(3);
      io_sw0 = 1'b0;
      idle(8);
      rd(16'hFFF2);

      // held high: still 0 after 5 edges, then 0005, then 0001
      io_sw0 = 1'b1;
      idle(5);
      rd(16'hFFF2);
      rd(16'hFFF2);
      rd(16'hFFF2);

      // sw1 rises while SW is polled every cycle
      io_sw1 = 1'b1;
      for (int i = 0; i < 8; i++) rd(16'hFFF2);
      rd(16'hFFF2);

      // timer wrap and overflow
      wr(16'hFFF4, 16'hFFFE);
      wr(16'hFFF6, 16'h0001);
      idle(2);
      rd(16'hFFF4);
      rd(16'hFFF6);
      wr(16'hFFF6, 16'h0005);
      rd(16'hFFF6);
      rd(16'hFFF4);

      // clear while running, then load while enabled
      wr(16'hFFF6, 16'h0003);
      rd(16'hFFF4);
      rd(16'hFFF4);
      wr(16'hFFF4, 16'h0100);
      rd(16'hFFF4);
      rd(16'hFFF4);

      // randomized traffic
      hold = 0;
      for (int i = 0; i < 500; i++) begin
         if (i == 250) async_reset();
         if (hold == 0) begin
            hold   = $urandom_range(1, 9);
            io_sw0 = 1'($urandom_range(0, 1));
            io_sw1 = 1'($urandom_range(0, 1));
         end
         hold--;
         k = $urandom_range(0, 9);
         if (k < 7) a = 16'hFFF0 + 16'(2 * $urandom_range(0, 3)) + 16'($urandom_range(0, 1));
         else if (k < 9) a = 16'hFFE0 + 16'($urandom_range(0, 31));
         else a = 16'($urandom);
         d  = 16'($urandom);
         op = $urandom_range(0, 9);
         if (op < 4) rd(a);
         else if (op < 6) wr(a, d);
         else idle(1);
      end

      idle(2);
      chk("sb_drain", 16'(sb_q.size()), 16'h0000);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
